riscv_trace_monitor: RTL and testbench
======================================

# riscv_trace_monitor

Synthesizable commit-trace monitor for the RISC-V core simulation and FPGA bring-up environment. It observes the core's PC and register-writeback stream and records every architectural register write, with its PC, into a circular buffer. It detects program end, defined as the PC parked on a self-loop, and then drains the buffer oldest-first over a valid/ready port. This replaces hierarchical register probing for checking programs such as FFT/IFFT results.

## Interface
Parameters:
- XLEN, 32, data and PC width
- DEPTH, 64, trace entries; power of two, ≥2
- HALT_CYCLES, 8, consecutive cycles with unchanged PC that declare halt; ≥1

Ports:
- clk  in  1  core clock; single clock domain
- rst  in  1  synchronous, active-high reset
- pc  in  XLEN  core current PC (u_pc.curr_pc)
- wb_en  in  1  register-file write enable this cycle
- wb_rd  in  5  destination register index
- wb_data  in  XLEN  write data
- rd_valid  out  1  trace entry available
- rd_ready  in  1  consumer accepts entry
- rd_pc  out  XLEN  entry PC
- rd_idx  out  5  entry destination register
- rd_data  out  XLEN  entry write data
- halted  out  1  halt detected (sticky until rst)
- done  out  1  drain complete (sticky until rst)
- overflow  out  1  at least one entry was overwritten (sticky)
- count  out  $clog2(DEPTH+1)  entries currently held

## Operation
- States: CAPTURE (after reset), HALTED, DRAIN, DONE.
- Record condition: state==CAPTURE, wb_en==1 and wb_rd!=0. Writes to x0 are never recorded.
- Record action:
  - Store {pc, wb_rd, wb_data} at wr_ptr, then increment wr_ptr mod DEPTH.
  - If count<DEPTH, increment count.
  - If count==DEPTH, overwrite the oldest entry, increment rd_ptr, and set overflow. count stays DEPTH.
- Halt detection:
  - pc_q is pc registered every cycle.
  - same_cnt increments (saturating) when pc==pc_q and clears otherwise.
  - When pc==pc_q and same_cnt==HALT_CYCLES-1, the next state is HALTED.
  - A record and the halt decision in the same cycle are both honoured: that final write is stored.
- HALTED lasts one cycle, then goes to DRAIN if count!=0, or to DONE if count==0.
- DRAIN:
  - rd_valid=1; rd_pc/rd_idx/rd_data = buffer[rd_ptr].
  - On rd_valid&&rd_ready: rd_ptr increments mod DEPTH and count decrements.
  - When the decrement takes count to 0, the next state is DONE.
- DONE: rd_valid=0. The block is inert until rst.
- halted=1 in HALTED, DRAIN and DONE.
- done=1 in DONE only.
- No recording occurs outside CAPTURE; wb_* inputs are ignored there.

## Timing
- Reset values:
  - state=CAPTURE.
  - rd_valid=0, halted=0, done=0, overflow=0, count=0.
  - rd_pc/rd_idx/rd_data=0 (buffer contents are don't-care, but rd_* outputs are gated to 0 while !rd_valid).
  - wr_ptr=rd_ptr=same_cnt=0, pc_q=0.
- Record latency:
  - Entry is written on the edge that samples wb_en.
  - count updates on the same edge.
- Halt latency:
  - pc held at value P starting in cycle t.
  - pc==pc_q first holds in cycle t+1.
  - halted rises after the edge ending cycle t+HALT_CYCLES.
- Drain timing:
  - rd_valid rises the cycle after HALTED.
  - Throughput is one entry per cycle with rd_ready held high.
  - rd_* are stable while rd_valid&&!rd_ready.
  - rd_valid falls the cycle after the last handshake.
- rst asserted in any state, including mid-drain, returns all state to reset values on the next edge. Buffered entries are discarded.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. count, not pointer equality, distinguishes full from empty.

## Configuration
- Macro: TRACE_REGMASK_EN.
- When defined:
  - Adds parameter REG_MASK (32 bits, default 32'hFFFF_FFFE).
  - The record condition additionally requires REG_MASK[wb_rd]==1.
  - Bit 0 is ignored; x0 is never recorded.
- When undefined:
  - No REG_MASK parameter exists.
  - All writes with wb_rd!=0 are recorded.

## Test plan
- Reset, idle: rst 2 cycles, pc toggles 0/4, no wb_en -> count=0, rd_valid=0, halted=0 indefinitely.
- Basic trace, DEPTH=8, HALT_CYCLES=4:
  - Stimulus: writes (pc=0x10,x5,0xA), (0x14,x0,0xB), (0x18,x10,0xC), then pc held at 0x1C.
  - Required response: count=2; halted rises 4 cycles after hold begins; drain with rd_ready=1 gives (0x10,5,0xA) then (0x18,10,0xC); done=1 and rd_valid=0 on the following cycle.
- Overflow, DEPTH=8:
  - Stimulus: 11 writes with data 1..11, then halt.
  - Required response: overflow=1, count=8; drain yields data 4..11 in order.
- Backpressure: during drain, rd_ready toggled 1,0,0,1 -> rd_* stable during the low cycles; no entry is skipped or duplicated.
- Halt with empty buffer: no writes, pc held -> HALTED then DONE directly; rd_valid never asserts.
- Reset mid-drain: rst after 2 of 5 entries are drained -> next cycle count=0, halted=0, done=0, state CAPTURE. With TRACE_REGMASK_EN and REG_MASK=32'h0000_0400, only x10 writes are recorded.

Source files
------------

// File: rtl/riscv_trace_monitor.sv
// Commit-trace monitor: records architectural register writes into a circular buffer,
// detects a PC self-loop as program end, then drains oldest-first. Optional macro: TRACE_REGMASK_EN.
module riscv_trace_monitor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned HALT_CYCLES = 8
`ifdef TRACE_REGMASK_EN
  ,
  parameter logic [31:0] REG_MASK    = 32'hFFFF_FFFE
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            pc,
  input  logic                       wb_en,
  input  logic [4:0]                 wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [XLEN-1:0]            rd_pc,
  output logic [4:0]                 rd_idx,
  output logic [XLEN-1:0]            rd_data,
  output logic                       halted,
  output logic                       done,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(HALT_CYCLES + 1);
  localparam int unsigned EW = 2 * XLEN + 5;

  typedef enum logic [1:0] {
    CAPTURE,
    HALTED,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] pc_q;
  logic [SW-1:0] same_cnt;
  logic          ovf;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] entry;

  logic          reg_ok;
  logic          rec;
  logic          pop;
  logic          full;
  logic          pc_same;
  logic          halt_hit;

  always_comb begin
`ifdef TRACE_REGMASK_EN
    reg_ok = REG_MASK[wb_rd];
`else
    reg_ok = 1'b1;
`endif
    rec      = (state == CAPTURE) && wb_en && (wb_rd != '0) && reg_ok;
    full     = (cnt == CW'(DEPTH));
    pop      = (state == DRAIN) && rd_ready;
    pc_same  = (pc == pc_q);
    halt_hit = pc_same && (same_cnt == SW'(HALT_CYCLES - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      CAPTURE: if (halt_hit) state_next = HALTED;
      HALTED:  state_next = (cnt != '0) ? DRAIN : DONE;
      DRAIN:   if (pop && (cnt == CW'(1))) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CAPTURE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      pc_q     <= '0;
      same_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_next;
      pc_q  <= pc;
      if (!pc_same) begin
        same_cnt <= '0;
      end else if (same_cnt != SW'(HALT_CYCLES)) begin
        same_cnt <= same_cnt + SW'(1);
      end
      // Record and pop are exclusive by state; a full buffer drops its oldest entry.
      if (rec) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (full) begin
          rd_ptr <= rd_ptr + AW'(1);
          ovf    <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        cnt    <= cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rec) begin
      mem[wr_ptr] <= {pc, wb_rd, wb_data};
    end
  end

  always_comb begin
    entry    = mem[rd_ptr];
    rd_valid = (state == DRAIN);
    rd_pc    = '0;
    rd_idx   = '0;
    rd_data  = '0;
    if (rd_valid) begin
      rd_pc   = entry[EW-1 -: XLEN];
      rd_idx  = entry[XLEN +: 5];
      rd_data = entry[XLEN-1:0];
    end
    halted   = (state != CAPTURE);
    done     = (state == DONE);
    overflow = ovf;
    count    = cnt;
  end

endmodule

// File: tb/tb_riscv_trace_monitor.sv
// Scoreboard bench for riscv_trace_monitor (DEPTH=8, HALT_CYCLES=4); honours TRACE_REGMASK_EN.
module tb_riscv_trace_monitor;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned HC    = 4;
`ifdef TRACE_REGMASK_EN
  localparam logic [31:0] MASK = 32'h0000_0400;
`else
  localparam logic [31:0] MASK = 32'hFFFF_FFFE;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  idx;
    logic [31:0] data;
  } ent_t;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] pc;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] rd_data;
  logic            halted;
  logic            done;
  logic            overflow;
  logic [$clog2(DEPTH+1)-1:0] count;

  ent_t sb[$];
  logic exp_ovf;
  int   tests_run;
  int   tests_failed;

  riscv_trace_monitor #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .HALT_CYCLES(HC)
`ifdef TRACE_REGMASK_EN
    ,
    .REG_MASK(MASK)
`endif
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_idx(rd_idx),
    .rd_data(rd_data), .halted(halted), .done(done), .overflow(overflow), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic record(input logic [31:0] p, input logic [4:0] r, input logic [31:0] d);
    if (r != 5'd0 && MASK[r]) begin
      if (sb.size() == DEPTH) begin
        void'(sb.pop_front());
        exp_ovf = 1'b1;
      end
      sb.push_back({p, r, d});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0; rd_ready = 1'b0; pc = '0;
    cyc();
    cyc();
    rst = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rd_pc", rd_pc, 0);
  endtask

  task automatic write(input logic [31:0] p, input logic [4:0] r, input logic [31:0] d);
    pc = p; wb_en = 1'b1; wb_rd = r; wb_data = d;
    record(p, r, d);
    cyc();
    wb_en = 1'b0;
    check("wr_count", count, sb.size());
    check("wr_ovf", overflow, exp_ovf);
  endtask

  task automatic hold_halt(input logic [31:0] p, input bit last_wr, input logic [4:0] r,
                           input logic [31:0] d);
    int lat;
    lat = 0;
    pc = p;
    while (lat < 40) begin
      lat++;
      if (last_wr && lat == HC + 1) begin
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        record(p, r, d);
      end
      cyc();
      wb_en = 1'b0;
      if (halted) break;
    end
    check("halt_latency", lat, HC + 1);
    check("halt_halted", halted, 1);
    check("halt_done", done, 0);
    check("halt_valid", rd_valid, 0);
    check("halt_count", count, sb.size());
    check("halt_ovf", overflow, exp_ovf);
  endtask

  task automatic drain(input int max_pops, input logic [3:0] pat);
    int pops;
    int budget;
    pops = 0;
    budget = 0;
    cyc();
    while (sb.size() > 0 && pops < max_pops && budget < 200) begin
      budget++;
      check("drain_valid", rd_valid, 1);
      if (!rd_valid) break;
      check("drain_pc", rd_pc, sb[0].pc);
      check("drain_idx", rd_idx, sb[0].idx);
      check("drain_data", rd_data, sb[0].data);
      rd_ready = pat[budget % 4 == 0 ? 3 : (budget % 4) - 1];
      if (rd_ready) begin
        void'(sb.pop_front());
        pops++;
      end
      cyc();
      rd_ready = 1'b0;
    end
    if (sb.size() == 0) begin
      check("end_done", done, 1);
      check("end_valid", rd_valid, 0);
      check("end_count", count, 0);
      check("end_halted", halted, 1);
    end else begin
      check("part_count", count, sb.size());
      check("part_valid", rd_valid, 1);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;

    // Idle: PC toggles, nothing written, never halts.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pc = (i % 2 == 0) ? 32'h4 : 32'h0;
      cyc();
      check("idle_count", count, 0);
      check("idle_valid", rd_valid, 0);
      check("idle_halted", halted, 0);
    end

    // Basic trace including an x0 write, then inertness in DONE.
    do_reset();
    write(32'h10, 5'd5, 32'hA);
    write(32'h14, 5'd0, 32'hB);
    write(32'h18, 5'd10, 32'hC);
    hold_halt(32'h1C, 1'b0, 5'd0, 32'h0);
    drain(99, 4'b1111);
    wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h77; pc = 32'h80;
    cyc();
    wb_en = 1'b0;
    check("inert_count", count, 0);
    check("inert_done", done, 1);

    // Overflow: 11 writes into 8 entries.
    do_reset();
    for (int i = 1; i <= 11; i++) write(32'h100 + 32'(4 * i), 5'd10, 32'(i));
    hold_halt(32'h200, 1'b0, 5'd0, 32'h0);
    drain(99, 4'b1111);

    // Backpressure, with a write landing on the halt-decision cycle.
    do_reset();
    write(32'h300, 5'd3, 32'h31);
    write(32'h304, 5'd10, 32'h32);
    write(32'h308, 5'd7, 32'h33);
    write(32'h30C, 5'd10, 32'h34);
    write(32'h310, 5'd12, 32'h35);
    hold_halt(32'h314, 1'b1, 5'd10, 32'h55);
    drain(99, 4'b1001);

    // Halt with an empty buffer.
    do_reset();
    hold_halt(32'h40, 1'b0, 5'd0, 32'h0);
    drain(99, 4'b1111);

    // Reset mid-drain, then capture resumes.
    do_reset();
    write(32'h400, 5'd10, 32'h41);
    write(32'h404, 5'd10, 32'h42);
    write(32'h408, 5'd4, 32'h43);
    write(32'h40C, 5'd10, 32'h44);
    write(32'h410, 5'd10, 32'h45);
    hold_halt(32'h414, 1'b0, 5'd0, 32'h0);
    drain(2, 4'b1111);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    check("mid_count", count, 0);
    check("mid_halted", halted, 0);
    check("mid_done", done, 0);
    check("mid_valid", rd_valid, 0);
    write(32'h500, 5'd10, 32'h99);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
